// File: rtl/rapid_pkg.sv
// rapid_pkg: shared types and constants for the rapid core front end.
package rapid_pkg;

  // Fetch stage state; prefixed names keep them clear of other enums in the core.
  typedef enum logic [0:0] {
    FS_FETCH = 1'b0,
    FS_HALT  = 1'b1
  } fetch_state_t;

  // Every instruction is one 32-bit word.
  localparam int INSTR_BYTES = 4;

  // Native datapath width of the core.
  localparam int RAPID_XLEN = 32;

  // One prefetch queue entry: the pc and the instruction found there.
  // The fetch queue packs entries flat in this same field order (pc high, instr low).
  typedef struct packed {
    logic [RAPID_XLEN-1:0] pc;
    logic [RAPID_XLEN-1:0] instr;
  } fetch_entry_s;

endpackage

// File: rtl/rapid_sync_fifo.sv
// rapid_sync_fifo: register-based synchronous FIFO with flush and occupancy count.
// The head entry is read straight from the storage registers, so a write is
// visible at the output one cycle later (no write-to-read bypass).
module rapid_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     pop_valid,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign pop_valid = (count_q != '0);
  assign pop_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Pointer/count bookkeeping; a full FIFO still accepts a push when it pops in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rapid_fetch_queue.sv
// rapid_fetch_queue: in-order instruction fetch with a DEPTH-entry prefetch queue,
// redirect flush with stale-response discard, and halt/resume.
// Optional macro RAPID_FETCH_PERF_EN adds perf_fetched/perf_stall/perf_discarded counters.
module rapid_fetch_queue
  import rapid_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              DEPTH        = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted
`ifdef RAPID_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_discarded
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]     fifo_count;
  logic [2*XLEN-1:0] fifo_head;
  logic [XLEN-1:0]   redirect_word;
  logic              credit_ok, req_fire, rsp_ok, rsp_push, rsp_drop;

  assign redirect_word = redirect_pc & ~XLEN'(3);

  // Request issue and response classification; credits reserve a queue slot for every request in flight.
  always_comb begin
    credit_ok     = (SW'(fifo_count) + SW'(outstanding_q)) < SW'(DEPTH);
    mem_req_valid = (state_q == FS_FETCH) && credit_ok && !redirect_valid && !reset;
    mem_req_addr  = fetch_pc_q;
    req_fire      = mem_req_valid && mem_req_ready;
    rsp_ok        = mem_rsp_valid && (outstanding_q != '0);
    rsp_push      = rsp_ok && (discard_q == '0) && !redirect_valid;
    rsp_drop      = rsp_ok && !rsp_push;
  end

  // Next-state for the FSM, the two pc pointers and the in-flight/discard counters.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
    discard_d     = discard_q;
    case (state_q)
      FS_FETCH: if (halt && !redirect_valid) state_d = FS_HALT;
      FS_HALT:  if (redirect_valid) state_d = FS_FETCH;
      default:  state_d = FS_FETCH;
    endcase
    if (redirect_valid) begin
      // Every response still in flight is stale now, including ones already
      // marked for discard, since outstanding counts all of them.
      fetch_pc_d = redirect_word;
      rsp_pc_d   = redirect_word;
      discard_d  = outstanding_q - CW'(rsp_ok);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_push) rsp_pc_d = rsp_pc_q + PC_STEP;
      if (rsp_drop) discard_d = discard_q - CW'(1);
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FS_FETCH;
      fetch_pc_q    <= RESET_VECTOR;
      rsp_pc_q      <= RESET_VECTOR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  rapid_sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (rsp_push),
    .push_data ({rsp_pc_q, mem_rsp_data}),
    .pop       (out_ready),
    .pop_valid (out_valid),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

  assign out_pc    = fifo_head[2*XLEN-1:XLEN];
  assign out_instr = fifo_head[XLEN-1:0];
  assign halted    = (state_q == FS_HALT) && (outstanding_q == '0);

  // A response with nothing outstanding breaks the cache protocol; it is ignored above.
  assert property (@(posedge clk) disable iff (reset) mem_rsp_valid |-> (outstanding_q != '0));

`ifdef RAPID_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_discarded_q, perf_discarded_d;

  // Wrapping event counters: decode handshakes, starved fetch cycles, dropped responses.
  always_comb begin
    perf_fetched_d   = perf_fetched_q + 32'(out_valid && out_ready);
    perf_stall_d     = perf_stall_q + 32'((state_q == FS_FETCH) && !out_valid);
    perf_discarded_d = perf_discarded_q + 32'(rsp_drop);
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q   <= '0;
      perf_stall_q     <= '0;
      perf_discarded_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_stall_q     <= perf_stall_d;
      perf_discarded_q <= perf_discarded_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_stall     = perf_stall_q;
  assign perf_discarded = perf_discarded_q;
`endif

endmodule

// File: tb/tb_rapid_fetch_queue.sv
// tb_rapid_fetch_queue: directed scenarios with a scoreboard of expected (pc, instr) pairs.
module tb_rapid_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
`ifdef RAPID_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_discarded;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] pend[$];
  int          budget;
  bit          hold_rsp;
  int          accepted;
  int          errors;
  int          checks;
  int          obs_fetched;

  rapid_fetch_queue #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0),
    .DEPTH        (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted)
`ifdef RAPID_FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_discarded (perf_discarded)
`endif
  );

  always #5 clk = ~clk;

  assign mem_req_ready = (budget != 0);

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expectPc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = instrOf(pc);
    sb.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Drives one cycle of control inputs; bud < 0 leaves the cache accept budget untouched.
  task automatic applyStimulus(input bit rv, input logic [31:0] rpc, input bit h,
                               input bit ordy, input int bud, input bit hold);
    nextCycle();
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    out_ready      = ordy;
    hold_rsp       = hold;
    if (bud >= 0) budget = bud;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    checkOutput(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Cache model: accepts while budget lasts, answers in order one cycle later unless held.
  initial begin
    bit          fire;
    logic [31:0] fa;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      fire = mem_req_valid && mem_req_ready && !reset;
      fa   = mem_req_addr;
      @(posedge clk);
      #1;
      if (reset) begin
        pend.delete();
        mem_rsp_valid = 1'b0;
      end else begin
        if (fire) begin
          pend.push_back(fa);
          budget--;
          accepted++;
        end
        if (!hold_rsp && pend.size() > 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = instrOf(pend.pop_front());
        end else begin
          mem_rsp_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: every decode handshake is checked against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        obs_fetched = 0;
      end else if (out_valid && out_ready) begin
        obs_fetched++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out: got pc 0x%08h, expected no output", out_pc);
        end else begin
          e = sb.pop_front();
          checkOutput("out_pc", out_pc, e.pc);
          checkOutput("out_instr", out_instr, e.instr);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    out_ready = 1'b1; budget = 0; hold_rsp = 1'b0;
    accepted = 0; errors = 0; checks = 0; obs_fetched = 0;
    repeat (3) @(posedge clk);
    #2;

    // Reset values, then a 1-cycle cache streaming eight words with no bubbles.
    budget = 8;
    for (int i = 0; i < 8; i++) expectPc(32'(i * 4));
    @(negedge clk);
    checkOutput("rst_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("first_req_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("first_req_addr", mem_req_addr, 32'h0);
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checkOutput("stream_nobubble", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    waitDrain("s1_drain");
    @(negedge clk);
    checkOutput("s1_stall_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("s1_stall_addr", mem_req_addr, 32'h20);

    // Decode stalled: credits stop issue after exactly DEPTH requests.
    begin
      int acc0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 8, 1'b0);
      acc0 = accepted;
      repeat (10) @(negedge clk);
      checkOutput("credit_block", 32'(mem_req_valid), 32'd0);
      checkOutput("credit_accepts", 32'(accepted - acc0), 32'd4);
      checkOutput("credit_full_valid", 32'(out_valid), 32'd1);
    end
    for (int i = 0; i < 8; i++) expectPc(32'h20 + 32'(i * 4));
    applyStimulus(1'b0, '0, 1'b0, 1'b1, -1, 1'b0);
    waitDrain("s2_drain");
    @(negedge clk);
    checkOutput("s2_stall_addr", mem_req_addr, 32'h40);

    // Reset with requests in flight, then redirect with two stale responses outstanding.
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 3, 1'b1);
    repeat (2) nextCycle();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    nextCycle();
    budget = 4;
    hold_rsp = 1'b0;
    for (int i = 0; i < 4; i++) expectPc(32'(i * 4));
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_restart_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("midrst_restart_addr", mem_req_addr, 32'h0);
    waitDrain("s3a_drain");
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 2, 1'b1);
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("s3_next_addr", mem_req_addr, 32'h18);
    applyStimulus(1'b1, 32'h203, 1'b0, 1'b1, 2, 1'b1);
    expectPc(32'h200);
    expectPc(32'h204);
    @(negedge clk);
    checkOutput("redirect_blocks_req", 32'(mem_req_valid), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, -1, 1'b0);
    @(negedge clk);
    checkOutput("redirect_req_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("redirect_req_addr", mem_req_addr, 32'h200);
    checkOutput("redirect_out_valid", 32'(out_valid), 32'd0);
    waitDrain("s3_drain");
    repeat (2) @(negedge clk);
`ifdef RAPID_FETCH_PERF_EN
    checkOutput("perf_discarded_s3", perf_discarded, 32'd2);
    checkOutput("perf_fetched_s3", perf_fetched, 32'(obs_fetched));
`endif

    // Redirect in the same cycle as a response: that one and the other stale one are dropped.
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 2, 1'b1);
    repeat (3) nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, -1, 1'b0);
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b1, 2, 1'b0);
    expectPc(32'h300);
    expectPc(32'h304);
    @(negedge clk);
    checkOutput("s4_redirect_blocks_req", 32'(mem_req_valid), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, -1, 1'b0);
    waitDrain("s4_drain");
    @(negedge clk);
    checkOutput("s4_stall_addr", mem_req_addr, 32'h308);

    // Halt with two outstanding; halted only after both return; resume only on redirect.
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 2, 1'b1);
    repeat (3) nextCycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b1, -1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 3, 1'b1);
    repeat (2) nextCycle();
    @(negedge clk);
    checkOutput("halt_no_req", 32'(mem_req_valid), 32'd0);
    checkOutput("halted_pending", 32'(halted), 32'd0);
    expectPc(32'h308);
    expectPc(32'h30C);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, -1, 1'b0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("halted_early", 32'(halted), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("halted_rise", 32'(halted), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, -1, 1'b0);
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("halted_sticky", 32'(halted), 32'd1);
    checkOutput("halt_sticky_req", 32'(mem_req_valid), 32'd0);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1, -1, 1'b0);
    expectPc(32'h40);
    expectPc(32'h44);
    expectPc(32'h48);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, -1, 1'b0);
    @(negedge clk);
    checkOutput("resume_req_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("resume_req_addr", mem_req_addr, 32'h40);
    checkOutput("resume_halted", 32'(halted), 32'd0);
    waitDrain("s5_drain");

    // Address wrap at the top of the space; low redirect bits are ignored.
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 2, 1'b0);
    expectPc(32'hFFFF_FFFC);
    expectPc(32'h0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, -1, 1'b0);
    @(negedge clk);
    checkOutput("wrap_req_addr", mem_req_addr, 32'hFFFF_FFFC);
    waitDrain("s6_drain");
    @(negedge clk);
    checkOutput("wrap_stall_addr", mem_req_addr, 32'h4);

    repeat (2) @(negedge clk);
`ifdef RAPID_FETCH_PERF_EN
    checkOutput("perf_discarded_end", perf_discarded, 32'd4);
    checkOutput("perf_fetched_end", perf_fetched, 32'(obs_fetched));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
